// File: rtl/demux_logic_router.sv
// Bitwise logic unit feeding a 2-entry result FIFO that routes each result to one of NCH channels.
// Optional macro DEMUX_LOGIC_ROUTER_PARITY_EN adds out_parity, stored per entry at push time.
module demux_logic_router #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NCH    = 4,
  parameter int unsigned DEST_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  input  logic [2:0]        in_op,
  input  logic [DEST_W-1:0] in_dest,
  output logic [NCH-1:0]    out_valid,
  input  logic [NCH-1:0]    out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [7:0]        drop_cnt
`ifdef DEMUX_LOGIC_ROUTER_PARITY_EN
  ,
  output logic              out_parity
`endif
);

  localparam int unsigned CNT_W = 2;
  localparam logic [CNT_W-1:0] CNT_FULL = 2'd2;
  localparam logic [7:0] DROP_MAX = 8'hFF;

  logic [WIDTH-1:0]  r_data [2];
  logic [DEST_W-1:0] r_dest [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_in_ready;
  logic [NCH-1:0]    r_out_valid;
  logic [WIDTH-1:0]  r_out_data;
  logic [7:0]        r_drop_cnt;

  logic [WIDTH-1:0]  w_result;
  logic              w_dest_ok;
  logic              w_accept;
  logic              w_push;
  logic              w_drop;
  logic              w_pop;
  logic [CNT_W-1:0]  w_count_nxt;
  logic              w_wr_ptr_nxt;
  logic              w_rd_ptr_nxt;
  logic [DEST_W-1:0] w_head_dest_nxt;
  logic [WIDTH-1:0]  w_head_data_nxt;
  logic [NCH-1:0]    w_out_valid_nxt;
  logic [WIDTH-1:0]  w_out_data_nxt;

`ifdef DEMUX_LOGIC_ROUTER_PARITY_EN
  logic r_par [2];
  logic r_out_parity;
  logic w_head_par_nxt;
  logic w_out_par_nxt;
`endif

  // Destination range check collapses to constant-true when every code is a real channel.
  generate
    if (NCH < (1 << DEST_W)) begin : g_dest_chk
      assign w_dest_ok = (in_dest < DEST_W'(NCH));
    end else begin : g_dest_all
      assign w_dest_ok = 1'b1;
    end
  endgenerate

  // Function unit
  always_comb begin
    w_result = '0;
    case (in_op)
      3'd0: w_result = ~in_a;
      3'd1: w_result = in_a;
      3'd2: w_result = in_a & in_b;
      3'd3: w_result = in_a | in_b;
      3'd4: w_result = ~(in_a & in_b);
      3'd5: w_result = ~(in_a | in_b);
      3'd6: w_result = in_a ^ in_b;
      3'd7: w_result = ~(in_a ^ in_b);
      default: w_result = '0;
    endcase
  end

  // Handshake decode and next head; outputs are registered from the post-edge FIFO view.
  always_comb begin
    w_accept     = in_valid & r_in_ready;
    w_push       = w_accept & w_dest_ok;
    w_drop       = w_accept & ~w_dest_ok;
    w_pop        = |(r_out_valid & out_ready);
    w_count_nxt  = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    w_wr_ptr_nxt = r_wr_ptr ^ w_push;
    w_rd_ptr_nxt = r_rd_ptr ^ w_pop;

    w_head_dest_nxt = r_dest[w_rd_ptr_nxt];
    w_head_data_nxt = r_data[w_rd_ptr_nxt];
`ifdef DEMUX_LOGIC_ROUTER_PARITY_EN
    w_head_par_nxt  = r_par[w_rd_ptr_nxt];
`endif
    if (w_push && (r_wr_ptr == w_rd_ptr_nxt)) begin
      w_head_dest_nxt = in_dest;
      w_head_data_nxt = w_result;
`ifdef DEMUX_LOGIC_ROUTER_PARITY_EN
      w_head_par_nxt  = ^w_result;
`endif
    end

    w_out_valid_nxt = '0;
    w_out_data_nxt  = '0;
`ifdef DEMUX_LOGIC_ROUTER_PARITY_EN
    w_out_par_nxt   = 1'b0;
`endif
    if (w_count_nxt != '0) begin
      w_out_valid_nxt = NCH'(1) << w_head_dest_nxt;
      w_out_data_nxt  = w_head_data_nxt;
`ifdef DEMUX_LOGIC_ROUTER_PARITY_EN
      w_out_par_nxt   = w_head_par_nxt;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_data[i] <= '0;
        r_dest[i] <= '0;
`ifdef DEMUX_LOGIC_ROUTER_PARITY_EN
        r_par[i]  <= 1'b0;
`endif
      end
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_count     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= '0;
      r_out_data  <= '0;
      r_drop_cnt  <= '0;
`ifdef DEMUX_LOGIC_ROUTER_PARITY_EN
      r_out_parity <= 1'b0;
`endif
    end else begin
      if (w_push) begin
        r_data[r_wr_ptr] <= w_result;
        r_dest[r_wr_ptr] <= in_dest;
`ifdef DEMUX_LOGIC_ROUTER_PARITY_EN
        r_par[r_wr_ptr]  <= ^w_result;
`endif
      end
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_count     <= w_count_nxt;
      r_in_ready  <= (w_count_nxt != CNT_FULL);
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
      if (w_drop && (r_drop_cnt != DROP_MAX)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
`ifdef DEMUX_LOGIC_ROUTER_PARITY_EN
      r_out_parity <= w_out_par_nxt;
`endif
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign drop_cnt  = r_drop_cnt;
`ifdef DEMUX_LOGIC_ROUTER_PARITY_EN
  assign out_parity = r_out_parity;
`endif

endmodule

// File: tb/tb_demux_logic_router.sv
// Scoreboard bench for demux_logic_router: truth-table reference model, queue of expected results,
// independent monitor that checks every presented output and retires entries on handshake.
module tb_demux_logic_router;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned NCH    = 4;
  localparam int unsigned DEST_W = 3;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_a;
  logic [WIDTH-1:0]  in_b;
  logic [2:0]        in_op;
  logic [DEST_W-1:0] in_dest;
  logic [NCH-1:0]    out_valid;
  logic [NCH-1:0]    out_ready;
  logic [WIDTH-1:0]  out_data;
  logic [7:0]        drop_cnt;
`ifdef DEMUX_LOGIC_ROUTER_PARITY_EN
  logic              out_parity;
`endif

  demux_logic_router #(.WIDTH(WIDTH), .NCH(NCH), .DEST_W(DEST_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_dest   (in_dest),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .drop_cnt  (drop_cnt)
`ifdef DEMUX_LOGIC_ROUTER_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  typedef struct {
    logic [DEST_W-1:0] dest;
    logic [WIDTH-1:0]  data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_h;
  int   n_checks = 0;
  int   n_errors = 0;
  int   exp_drop = 0;
  bit   rnd_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: each op is a 2-input truth table indexed by {a_bit, b_bit}, applied per bit.
  function automatic logic [WIDTH-1:0] ref_fn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic [2:0] op);
    logic [3:0] tt;
    logic [WIDTH-1:0] r;
    case (op)
      3'd0: tt = 4'b0011;
      3'd1: tt = 4'b1100;
      3'd2: tt = 4'b1000;
      3'd3: tt = 4'b1110;
      3'd4: tt = 4'b0111;
      3'd5: tt = 4'b0001;
      3'd6: tt = 4'b0110;
      default: tt = 4'b1001;
    endcase
    for (int i = 0; i < int'(WIDTH); i++) r[i] = tt[{a[i], b[i]}];
    return r;
  endfunction

  // Called at posedge+1; leaves in_valid high so back-to-back calls stream one beat per cycle.
  task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [2:0] op, input logic [DEST_W-1:0] dest);
    exp_t e;
    bit ok;
    in_valid = 1'b1;
    in_a = a; in_b = b; in_op = op; in_dest = dest;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    if (int'(dest) < int'(NCH)) begin
      e.dest = dest;
      e.data = ref_fn(a, b, op);
      exp_q.push_back(e);
    end else begin
      exp_drop = (exp_drop >= 255) ? 255 : exp_drop + 1;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 300 && exp_q.size() != 0; n++) @(posedge clk);
    #1;
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: checks the presented head every cycle, retires it when the handshake will fire.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid != '0) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", 32'(out_valid), 32'd0);
        end else begin
          mon_h = exp_q[0];
          check("out_valid", 32'(out_valid), 32'(NCH'(1) << mon_h.dest));
          check("out_data", 32'(out_data), 32'(mon_h.data));
`ifdef DEMUX_LOGIC_ROUTER_PARITY_EN
          check("out_parity", 32'(out_parity), 32'(^mon_h.data));
`endif
          if ((out_valid & out_ready) != '0) void'(exp_q.pop_front());
        end
      end else begin
        check("idle_data", 32'(out_data), 32'd0);
`ifdef DEMUX_LOGIC_ROUTER_PARITY_EN
        check("idle_parity", 32'(out_parity), 32'd0);
`endif
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_dest = '0;
    out_ready = '0; rnd_done = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    @(posedge clk); #1;

    // All eight functions on channel 1
    out_ready = 4'b0010;
    for (int op = 0; op < 8; op++) drive(8'hC5, 8'h3A, 3'(op), 3'd1);
    idle(1);
    wait_drain();

    // Backpressure: two entries fill the buffer, third waits for channel 2 ready
    out_ready = 4'b0000;
    drive(8'hF0, 8'hFF, 3'd2, 3'd2);
    drive(8'h0F, 8'hFF, 3'd2, 3'd2);
    in_valid = 1'b0;
    check("full_in_ready", 32'(in_ready), 32'd0);
    fork
      begin drive(8'hAA, 8'hFF, 3'd2, 3'd2); in_valid = 1'b0; end
      begin repeat (3) @(posedge clk); #1; out_ready = 4'b0100; end
    join
    wait_drain();
    check("bp_in_ready", 32'(in_ready), 32'd1);

    // Ready on other channels must not pop a channel-3 head
    out_ready = 4'b0111;
    drive(8'h5A, 8'h00, 3'd1, 3'd3);
    idle(5);
    check("hold_valid", 32'(out_valid), 32'(4'b1000));
    check("hold_data", 32'(out_data), 32'h5A);
    out_ready = 4'b1000;
    @(posedge clk); #1;
    check("popped_valid", 32'(out_valid), 32'd0);
    wait_drain();

    // Invalid destinations are accepted and counted, never presented
    out_ready = '1;
    for (int i = 0; i < 4; i++) drive(8'h11, 8'h22, 3'd3, 3'd4);
    idle(1);
    check("drop_4", 32'(drop_cnt), 32'(exp_drop));
    check("drop_no_valid", 32'(out_valid), 32'd0);

    // Randomized traffic with random per-channel ready
    fork
      begin
        for (int t = 0; t < 150; t++) begin
          if ($urandom_range(0, 3) == 0) idle(1);
          else drive(8'($urandom), 8'($urandom), 3'($urandom), 3'($urandom_range(0, 5)));
        end
        in_valid = 1'b0;
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          out_ready = 4'($urandom);
          @(posedge clk); #1;
        end
      end
    join
    out_ready = '1;
    wait_drain();
    check("rand_drop", 32'(drop_cnt), 32'(exp_drop));

    // Saturation
    for (int i = 0; i < 300; i++) drive(8'($urandom), 8'h00, 3'd1, 3'd5);
    idle(1);
    check("drop_sat", 32'(drop_cnt), 32'd255);

    // Parity / data of 0x07 held on channel 0
    out_ready = '0;
    drive(8'h07, 8'h00, 3'd1, 3'd0);
    idle(1);
    check("p07_valid", 32'(out_valid), 32'(4'b0001));
    check("p07_data", 32'(out_data), 32'h07);
`ifdef DEMUX_LOGIC_ROUTER_PARITY_EN
    check("p07_parity", 32'(out_parity), 32'd1);
`endif
    out_ready = '1;
    wait_drain();

    // Streaming at one beat per cycle, then asynchronous reset mid-stream
    for (int i = 0; i < 16; i++) begin
      check("stream_ready", 32'(in_ready), 32'd1);
      drive(8'($urandom), 8'($urandom), 3'($urandom), 3'($urandom_range(0, 3)));
    end
    check("stream_busy", 32'(out_valid != '0), 32'd1);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_data", 32'(out_data), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_drop_cnt", 32'(drop_cnt), 32'd0);
    exp_q.delete();
    exp_drop = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive(8'h3C, 8'h0F, 3'd6, 3'd2);
    idle(1);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
